collision_scan_engine: RTL and testbench

//  Parametrised successor to the single-target collision checker: registers an occupancy map plus
//  NUM_TGT target indices per request, then scans one target per clock. Returns a per-target hit

---
 rtl/collision_scan_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_collision_scan_engine.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scan_engine.sv
// collision_scan_engine
//   Latches an occupancy map plus NUM_TGT target indices on a request handshake, then probes one
//   target slot per clock. Publishes a per-slot hit vector, an any-hit flag, the lowest hit slot
//   and a sticky range error, held under a valid/ready handshake until consumed.
//
// Ports
//   iClk, iRstN          clock, asynchronous active-low reset
//   iValid / oReady      request handshake (oReady high only while idle)
//   iMap                 occupancy map, 1 = occupied
//   iTargets, iTgtMask   packed target indices (slot k at [k*IDX_W +: IDX_W]) and slot enables
//   oValid / iReady      result handshake
//   oHitVec, oAnyHit     per-slot collision flags and their OR
//   oFirstHit            lowest slot with a hit, 0 when none
//   oErr                 an enabled slot carried an out-of-range index
//
// Optional feature (macro COLLISION_HIT_CNT_EN)
//   Adds iCntClr / oHitCnt: a saturating 16-bit count of consumed results with oAnyHit set.
//   iCntClr clears it synchronously and takes priority over an increment.

module collision_scan_engine #(
    parameter int unsigned MAP_W    = 160,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned NUM_TGT  = 4,
    parameter int unsigned BASE_OFF = 1,
    localparam int unsigned FH_W    = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [MAP_W-1:0]           iMap,
    input  logic [NUM_TGT*IDX_W-1:0]   iTargets,
    input  logic [NUM_TGT-1:0]         iTgtMask,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [NUM_TGT-1:0]         oHitVec,
    output logic                       oAnyHit,
    output logic [FH_W-1:0]            oFirstHit,
    output logic                       oErr
`ifdef COLLISION_HIT_CNT_EN
    ,
    input  logic                       iCntClr,
    output logic [15:0]                oHitCnt
`endif
);

    // Index arithmetic is done one bit wider than a map index so that target > limit is a plain
    // unsigned compare and the subtraction never wraps.
    localparam int unsigned AW    = $clog2(MAP_W) + 1;
    localparam int unsigned CNT_W = FH_W;
    localparam logic [AW-1:0]    LIM  = AW'(MAP_W - 1 - BASE_OFF);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TGT - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                     state_q, state_d;
    logic [MAP_W-1:0]           map_q, map_d;
    logic [NUM_TGT*IDX_W-1:0]   tgt_q, tgt_d;
    logic [NUM_TGT-1:0]         mask_q, mask_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_TGT-1:0]         hit_acc_q, hit_acc_d;
    logic                       err_acc_q, err_acc_d;
    logic                       rdy_q, rdy_d;
    logic                       vld_q, vld_d;
    logic [NUM_TGT-1:0]         hit_vec_q, hit_vec_d;
    logic                       any_q, any_d;
    logic [FH_W-1:0]            first_q, first_d;
    logic                       err_q, err_d;

    logic [IDX_W-1:0]           cur_tgt;
    logic                       cur_en;
    logic [AW-1:0]              tgt_ext;
    logic [AW-1:0]              bit_idx;
    logic [MAP_W-1:0]           map_shift;
    logic                       oor;
    logic                       slot_hit;
    logic                       slot_err;
    logic [FH_W-1:0]            first_enc;

    // Slot currently addressed by the scan counter.
    always_comb begin
        cur_tgt = '0;
        cur_en  = 1'b0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                cur_tgt = tgt_q[k*IDX_W +: IDX_W];
                cur_en  = mask_q[k];
            end
        end
    end

    // Probe: out-of-range index counts as a collision with the map edge.
    always_comb begin
        tgt_ext   = AW'(cur_tgt);
        oor       = (tgt_ext > LIM);
        bit_idx   = LIM - tgt_ext;
        map_shift = map_q >> bit_idx;
        slot_hit  = cur_en & (oor | map_shift[0]);
        slot_err  = cur_en & oor;
    end

    // Lowest set slot wins.
    always_comb begin
        first_enc = '0;
        for (int k = NUM_TGT - 1; k >= 0; k--) begin
            if (hit_acc_q[k]) begin
                first_enc = FH_W'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        map_d     = map_q;
        tgt_d     = tgt_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        hit_acc_d = hit_acc_q;
        err_acc_d = err_acc_q;
        vld_d     = vld_q;
        hit_vec_d = hit_vec_q;
        any_d     = any_q;
        first_d   = first_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (iValid) begin
                    map_d     = iMap;
                    tgt_d     = iTargets;
                    mask_d    = iTgtMask;
                    cnt_d     = '0;
                    hit_acc_d = '0;
                    err_acc_d = 1'b0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                for (int k = 0; k < NUM_TGT; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        hit_acc_d[k] = slot_hit;
                    end
                end
                err_acc_d = err_acc_q | slot_err;
                if (cnt_q == LAST) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // First DONE cycle publishes the accumulated result; afterwards it is held.
                if (!vld_q) begin
                    vld_d     = 1'b1;
                    hit_vec_d = hit_acc_q;
                    any_d     = |hit_acc_q;
                    first_d   = first_enc;
                    err_d     = err_acc_q;
                end else if (iReady) begin
                    vld_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rdy_d = (state_d == StIdle);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= StIdle;
            map_q     <= '0;
            tgt_q     <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            hit_acc_q <= '0;
            err_acc_q <= 1'b0;
            rdy_q     <= 1'b1;
            vld_q     <= 1'b0;
            hit_vec_q <= '0;
            any_q     <= 1'b0;
            first_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            map_q     <= map_d;
            tgt_q     <= tgt_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            hit_acc_q <= hit_acc_d;
            err_acc_q <= err_acc_d;
            rdy_q     <= rdy_d;
            vld_q     <= vld_d;
            hit_vec_q <= hit_vec_d;
            any_q     <= any_d;
            first_q   <= first_d;
            err_q     <= err_d;
        end
    end

    assign oReady    = rdy_q;
    assign oValid    = vld_q;
    assign oHitVec   = hit_vec_q;
    assign oAnyHit   = any_q;
    assign oFirstHit = first_q;
    assign oErr      = err_q;

`ifdef COLLISION_HIT_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (iCntClr) begin
            hit_cnt_d = '0;
        end else if (vld_q && iReady && any_q && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign oHitCnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_collision_scan_engine.sv
// Testbench for collision_scan_engine. Two instances share the stimulus: dut_a uses the default
// geometry (probe limit 158), dut_b uses BASE_OFF=140 (probe limit 19) so that indices above 19
// are out of range there.

module tb_collision_scan_engine;

    localparam int LIM_A = 158;
    localparam int LIM_B = 19;
    localparam int LAT   = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic         ready;
    logic [159:0] map_i;
    logic [19:0]  tg_i;
    logic [3:0]   mask_i;
    logic         cnt_clr;

    logic         a_rdy, a_vld, a_any, a_err;
    logic [3:0]   a_hit;
    logic [1:0]   a_first;
    logic         b_rdy, b_vld, b_any, b_err;
    logic [3:0]   b_hit;
    logic [1:0]   b_first;
    logic [15:0]  a_cnt;
    logic [15:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    collision_scan_engine dut_a (
        .iClk      (clk),
        .iRstN     (rst_n),
        .iValid    (valid),
        .oReady    (a_rdy),
        .iMap      (map_i),
        .iTargets  (tg_i),
        .iTgtMask  (mask_i),
        .oValid    (a_vld),
        .iReady    (ready),
        .oHitVec   (a_hit),
        .oAnyHit   (a_any),
        .oFirstHit (a_first),
        .oErr      (a_err)
`ifdef COLLISION_HIT_CNT_EN
        ,
        .iCntClr   (cnt_clr),
        .oHitCnt   (a_cnt)
`endif
    );

    collision_scan_engine #(.BASE_OFF(140)) dut_b (
        .iClk      (clk),
        .iRstN     (rst_n),
        .iValid    (valid),
        .oReady    (b_rdy),
        .iMap      (map_i),
        .iTargets  (tg_i),
        .iTgtMask  (mask_i),
        .oValid    (b_vld),
        .iReady    (ready),
        .oHitVec   (b_hit),
        .oAnyHit   (b_any),
        .oFirstHit (b_first),
        .oErr      (b_err)
`ifdef COLLISION_HIT_CNT_EN
        ,
        .iCntClr   (cnt_clr),
        .oHitCnt   (b_cnt)
`endif
    );

    typedef struct {
        logic [3:0] hit;
        logic       anyh;
        logic [1:0] first;
        logic       err;
    } res_t;

    typedef struct {
        logic [159:0] map;
        logic [19:0]  tg;
        logic [3:0]   mask;
        res_t         exp;
    } vec_t;

    // Reference: each enabled slot probes bit lim-target; targets beyond lim are edge hits.
    function automatic res_t model(input logic [159:0] m, input logic [19:0] t,
                                   input logic [3:0] msk, input int lim);
        res_t r;
        bit   found;
        r.hit = '0;
        r.err = 1'b0;
        r.first = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int ti;
            ti = int'(t[k*5 +: 5]);
            if (msk[k]) begin
                if (ti > lim) begin
                    r.hit[k] = 1'b1;
                    r.err    = 1'b1;
                end else begin
                    r.hit[k] = m[lim - ti];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (r.hit[k] && !found) begin
                r.first = 2'(k);
                found   = 1'b1;
            end
        end
        r.anyh = |r.hit;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input res_t e);
        chk({tag, ".a_hit"},   32'(a_hit),   32'(e.hit));
        chk({tag, ".a_any"},   32'(a_any),   32'(e.anyh));
        chk({tag, ".a_first"}, 32'(a_first), 32'(e.first));
        chk({tag, ".a_err"},   32'(a_err),   32'(e.err));
    endtask

    task automatic chk_b(input string tag, input res_t e);
        chk({tag, ".b_hit"},   32'(b_hit),   32'(e.hit));
        chk({tag, ".b_any"},   32'(b_any),   32'(e.anyh));
        chk({tag, ".b_first"}, 32'(b_first), 32'(e.first));
        chk({tag, ".b_err"},   32'(b_err),   32'(e.err));
    endtask

    // Starts at a negedge; returns at the negedge after the accept edge with inputs scrambled.
    task automatic issue(input logic [159:0] m, input logic [19:0] t, input logic [3:0] k);
        int w = 0;
        while (!a_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_accept", 32'(a_rdy), 32'd1);
        map_i  = m;
        tg_i   = t;
        mask_i = k;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        map_i  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tg_i   = 20'($urandom);
        mask_i = 4'($urandom);
    endtask

    // Counts edges after the accept edge until oValid; iReady toggles randomly meanwhile.
    task automatic wait_result(input string tag);
        int lat = 0;
        while (!a_vld && lat < 20) begin
            ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(LAT));
        chk({tag, ".b_valid"}, 32'(b_vld), 32'd1);
    endtask

    task automatic finish_result(input string tag, input res_t ea);
        ready = 1'b1;
        if (ea.anyh) exp_cnt++;
        @(negedge clk);
        ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(a_vld), 32'd0);
        chk({tag, ".ready_back"}, 32'(a_rdy), 32'd1);
    endtask

    task automatic do_txn(input string tag, input logic [159:0] m, input logic [19:0] t,
                          input logic [3:0] k, input bit use_exp, input res_t exp_a);
        res_t ra, rb;
        ra = model(m, t, k, LIM_A);
        rb = model(m, t, k, LIM_B);
        if (use_exp) ra = exp_a;
        issue(m, t, k);
        wait_result(tag);
        chk_a(tag, ra);
        chk_b(tag, rb);
        finish_result(tag, ra);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t         vecs[6];
        res_t         none;
        res_t         ra, rb;
        logic [159:0] one;
        logic [159:0] m2;
        bit           stable;
        bit           saw_valid;

        one = 160'd1;
        none.hit = '0; none.anyh = 1'b0; none.first = '0; none.err = 1'b0;

        vecs[0].map = one << 159; vecs[0].tg = 20'h00000; vecs[0].mask = 4'b0001;
        vecs[0].exp.hit = 4'b0000; vecs[0].exp.anyh = 1'b0;
        vecs[0].exp.first = 2'd0;  vecs[0].exp.err = 1'b0;
        vecs[1].map = one << 158; vecs[1].tg = 20'h00020; vecs[1].mask = 4'b0011;
        vecs[1].exp.hit = 4'b0001; vecs[1].exp.anyh = 1'b1;
        vecs[1].exp.first = 2'd0;  vecs[1].exp.err = 1'b0;
        vecs[2].map = one << 157; vecs[2].tg = 20'h00020; vecs[2].mask = 4'b0011;
        vecs[2].exp.hit = 4'b0010; vecs[2].exp.anyh = 1'b1;
        vecs[2].exp.first = 2'd1;  vecs[2].exp.err = 1'b0;
        vecs[3].map = (one << 128) | (one << 127); vecs[3].tg = 20'hFFFFF; vecs[3].mask = 4'b1100;
        vecs[3].exp.hit = 4'b1100; vecs[3].exp.anyh = 1'b1;
        vecs[3].exp.first = 2'd2;  vecs[3].exp.err = 1'b0;
        vecs[4].map = '1; vecs[4].tg = 20'h18820; vecs[4].mask = 4'b0000;
        vecs[4].exp = none;
        vecs[5].map = '1; vecs[5].tg = 20'h18820; vecs[5].mask = 4'b1111;
        vecs[5].exp.hit = 4'b1111; vecs[5].exp.anyh = 1'b1;
        vecs[5].exp.first = 2'd0;  vecs[5].exp.err = 1'b0;

        valid = 1'b0; ready = 1'b0; cnt_clr = 1'b0;
        map_i = '0; tg_i = '0; mask_i = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.a_ready", 32'(a_rdy), 32'd1);
        chk("reset.a_valid", 32'(a_vld), 32'd0);
        chk_a("reset", none);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.a_ready", 32'(a_rdy), 32'd1);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].map, vecs[i].tg, vecs[i].mask, 1'b1,
                   vecs[i].exp);
        end

        // Out-of-range index on the narrow instance: target 25 in slot 3.
        issue('0, 20'd25 << 15, 4'b1000);
        wait_result("oor");
        chk("oor.b_err",   32'(b_err),   32'd1);
        chk("oor.b_hit",   32'(b_hit),   32'b1000);
        chk("oor.b_any",   32'(b_any),   32'd1);
        chk("oor.b_first", 32'(b_first), 32'd3);
        chk("oor.a_err",   32'(a_err),   32'd0);
        finish_result("oor", none);

        // Backpressure: result held for 10 cycles, second request ignored until released.
        issue(one << 156, 20'h00402, 4'b0110);
        wait_result("bp");
        ra = model(one << 156, 20'h00402, 4'b0110, LIM_A);
        m2 = one << 150;
        map_i = m2; tg_i = 20'h00008 << 15; mask_i = 4'b1000;
        valid = 1'b1;
        ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!a_vld || a_rdy || a_hit !== ra.hit || a_any !== ra.anyh ||
                a_first !== ra.first || a_err !== ra.err) stable = 1'b0;
        end
        chk("bp.hold_stable", 32'(stable), 32'd1);
        chk_a("bp", ra);
        finish_result("bp", ra);
        @(negedge clk);
        valid = 1'b0;
        chk("bp.second_accepted", 32'(a_rdy), 32'd0);
        map_i = '0;
        wait_result("bp2");
        rb = model(m2, 20'h00008 << 15, 4'b1000, LIM_A);
        chk_a("bp2", rb);
        finish_result("bp2", rb);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [159:0] m;
            logic [19:0]  t;
            logic [3:0]   k;
            m = {$urandom, $urandom, $urandom, $urandom, $urandom};
            t = 20'($urandom);
            k = 4'($urandom);
            if (i % 5 == 0) m = '0;
            do_txn($sformatf("rnd%0d", i), m, t, k, 1'b0, none);
        end

`ifdef COLLISION_HIT_CNT_EN
        chk("hit_cnt", 32'(a_cnt), 32'(exp_cnt));
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("hit_cnt_clr", 32'(a_cnt), 32'd0);
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) do_txn("cnt", '1, 20'h0, 4'b0001, 1'b0, none);
        chk("hit_cnt_three", 32'(a_cnt), 32'd3);
`endif

        // Leave a nonzero result in place, then reset during the second scan cycle.
        do_txn("pre_rst", '1, 20'd31 << 10, 4'b0101, 1'b0, none);
        issue('1, 20'h0, 4'b1111);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.a_ready", 32'(a_rdy), 32'd1);
        chk("mid_rst.a_valid", 32'(a_vld), 32'd0);
        chk_a("mid_rst", none);
        chk_b("mid_rst", none);
`ifdef COLLISION_HIT_CNT_EN
        chk("mid_rst.hit_cnt", 32'(a_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_vld || b_vld) saw_valid = 1'b1;
        end
        chk("mid_rst.no_valid", 32'(saw_valid), 32'd0);
        chk("mid_rst.ready", 32'(a_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
